// File: rtl/core_host_ctrl.sv
// core_host_ctrl: host-side job sequencer for the 9-bit-ISA core.
// Per job: LOAD operand bytes into data memory, KICK (reset) the core, RUN until done,
// then DRAIN result bytes out over a valid/ready stream. Host owns memory except in RUN.
// Optional build macro: CORE_WDOG_EN adds a RUN-cycle watchdog (TIMEOUT) and sticky timeout_err.
//
// Handshakes: a beat transfers on a rising clk edge where valid && ready are both high.
// A producer holds valid and data stable until the beat transfers. The consumer may
// change ready freely. in_* is accepted only in LOAD. out_* is produced only in DRAIN.
module core_host_ctrl #(
  parameter int AW        = 8,
  parameter int DW        = 8,
  parameter int LOAD_BASE = 0,
  parameter int LOAD_LEN  = 64,
  parameter int RES_BASE  = 64,
  parameter int RES_LEN   = 32,
  parameter int TIMEOUT   = 4096
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          core_reset,
  output logic          core_req,
  input  logic          core_done,
  output logic          mem_sel,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wr_data,
  input  logic [DW-1:0] mem_rd_data,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic          busy,
  output logic          timeout_err,
  output logic [2:0]    state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_KICK  = 3'd2,
    S_RUN   = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  localparam logic [AW:0]   LOAD_LAST = (AW+1)'(LOAD_LEN - 1);
  localparam logic [AW:0]   RES_CNT   = (AW+1)'(RES_LEN);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] LOAD_A    = AW'(LOAD_BASE);
  localparam logic [AW-1:0] RES_A     = AW'(RES_BASE);

  state_t        state;
  logic [AW:0]   cnt;        // beat counter, one bit wider so 2**AW fits
  logic          run_first;  // first RUN cycle: core PC still settling, ignore done
  logic          in_hs;
  logic          load_slot;
  logic [AW-1:0] load_addr;
  logic [AW-1:0] res_addr;

`ifdef CORE_WDOG_EN
  logic [15:0] wdog_cnt;
  logic        wdog_hit;
  assign wdog_hit = (wdog_cnt == 16'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign timeout_err    = 1'b0;
`endif

  // Address arithmetic wraps mod 2**AW by truncation.
  assign load_addr = LOAD_A + cnt[AW-1:0];
  assign res_addr  = RES_A + cnt[AW-1:0];
  assign in_hs     = (state == S_LOAD) && in_valid;
  assign load_slot = (state == S_DRAIN) && (!out_valid || out_ready);

  // State-decoded outputs; core_reset also follows the block reset directly.
  always_comb begin
    in_ready    = (state == S_LOAD);
    core_req    = (state == S_RUN);
    core_reset  = reset || (state == S_KICK) || (state == S_DRAIN);
    mem_sel     = (state != S_RUN);
    busy        = (state != S_IDLE);
    mem_wr_en   = in_hs;
    mem_wr_data = in_hs ? in_data : '0;
    mem_addr    = '0;
    if (in_hs)
      mem_addr = load_addr;
    else if (load_slot)
      mem_addr = res_addr;
    state_dbg   = state;
  end

  // Sequencer FSM with registered result stream and counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      run_first   <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
`ifdef CORE_WDOG_EN
      wdog_cnt    <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_LOAD;
            cnt   <= '0;
`ifdef CORE_WDOG_EN
            timeout_err <= 1'b0;
`endif
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            if (cnt == LOAD_LAST) begin
              cnt   <= '0;
              state <= S_KICK;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
        end
        S_KICK: begin
          state     <= S_RUN;
          run_first <= 1'b1;
`ifdef CORE_WDOG_EN
          wdog_cnt  <= '0;
`endif
        end
        S_RUN: begin
          run_first <= 1'b0;
`ifdef CORE_WDOG_EN
          wdog_cnt  <= wdog_cnt + 16'd1;
`endif
          // done wins over a coincident timeout
          if (core_done && !run_first) begin
            state <= S_DRAIN;
          end
`ifdef CORE_WDOG_EN
          else if (wdog_hit) begin
            timeout_err <= 1'b1;
            state       <= S_DRAIN;
          end
`endif
        end
        S_DRAIN: begin
          if (load_slot) begin
            if (cnt == RES_CNT) begin
              out_valid <= 1'b0;
              cnt       <= '0;
              state     <= S_IDLE;
            end else begin
              out_data  <= mem_rd_data;
              out_valid <= 1'b1;
              cnt       <= cnt + CNT_ONE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_host_ctrl.sv
// tb_core_host_ctrl: directed bench for core_host_ctrl with a byte memory model,
// a result scoreboard queue and a final summary line.
module tb_core_host_ctrl;

  logic       clk         = 1'b0;
  logic       reset       = 1'b0;
  logic       start       = 1'b0;
  logic       in_valid    = 1'b0;
  logic [7:0] in_data     = '0;
  logic       core_done   = 1'b0;
  logic       out_ready   = 1'b0;
  logic       in_ready, core_reset, core_req, mem_sel, mem_wr_en;
  logic [7:0] mem_addr, mem_wr_data, mem_rd_data, out_data;
  logic       out_valid, busy, timeout_err;
  logic [2:0] state_dbg;

  int         checks   = 0;
  int         errors   = 0;
  int         wr_count = 0;
  logic [7:0] mem [0:255];
  logic [7:0] exp_q[$];

  core_host_ctrl #(.TIMEOUT(100)) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .core_reset(core_reset), .core_req(core_req), .core_done(core_done),
    .mem_sel(mem_sel), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .timeout_err(timeout_err), .state_dbg(state_dbg)
  );

  // ---- clock ----
  always #5 clk = ~clk;

  // ---- memory model: operand region is real storage, result region (>=64) reads a ^ 0x5A ----
  always @(posedge clk) begin
    if (mem_wr_en) begin
      mem[mem_addr] <= mem_wr_data;
      wr_count      <= wr_count + 1;
    end
  end
  assign mem_rd_data = (mem_addr >= 8'd64) ? (mem_addr ^ 8'h5A) : mem[mem_addr];

  // ---- checker ----
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // ---- driver tasks (all return at a negedge, inputs driven there) ----
  task automatic start_job();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic load_bytes(input int n, input logic [7:0] pat);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i) ^ pat;
      #1;
      check("load_in_ready", in_ready, 1);
      check("load_wr_en", mem_wr_en, 1);
      check("load_addr", mem_addr, 8'(i));
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic check_kick();
    #1;
    check("kick_core_reset", core_reset, 1);
    check("kick_mem_sel", mem_sel, 1);
    check("kick_wr_en", mem_wr_en, 0);
    check("kick_core_req", core_req, 0);
    check("kick_busy", busy, 1);
    @(negedge clk);
  endtask

  // Pulse done on RUN cycle done_at (0 = never); returns RUN cycles observed.
  task automatic run_core(input int done_at, output int run_len);
    run_len = -1;
    for (int k = 1; k <= 300; k++) begin
      core_done = (k == done_at);
      #1;
      if (!core_req) begin
        run_len = k - 1;
        break;
      end
      if (k == 1) begin
        check("run_mem_sel", mem_sel, 0);
        check("run_core_reset", core_reset, 0);
      end
      @(negedge clk);
    end
    core_done = 1'b0;
    if (run_len < 0) check("run_bound", 0, 1);
  endtask

  // mode 0: out_ready held high; mode 1: out_ready toggles each cycle.
  task automatic drain(input int mode);
    int         beats, first_c, last_c, loaded;
    logic       stall_pending;
    logic [7:0] held;
    beats = 0; first_c = -1; last_c = -1; stall_pending = 1'b0; held = '0;
    exp_q.delete();
    for (int i = 0; i < 32; i++) exp_q.push_back(8'(64 + i) ^ 8'h5A);
    check("drain_core_reset", core_reset, 1);
    check("drain_mem_sel", mem_sel, 1);
    check("drain_core_req", core_req, 0);
    for (int c = 0; c < 200; c++) begin
      out_ready = (mode == 0) ? 1'b1 : c[0];
      #1;
      if (stall_pending) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, held);
      end
      if (!busy) break;
      loaded = beats + (out_valid ? 1 : 0);
      if ((!out_valid || out_ready) && loaded < 32)
        check("drain_addr", mem_addr, 8'(64 + loaded));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("extra_beat", 1, 0);
        else check("drain_data", out_data, exp_q.pop_front());
        if (first_c < 0) first_c = c;
        last_c = c;
        beats++;
      end
      stall_pending = out_valid && !out_ready;
      held          = out_data;
      @(negedge clk);
    end
    out_ready = 1'b0;
    check("drain_beats", beats, 32);
    check("drain_q_empty", exp_q.size(), 0);
    check("drain_idle_busy", busy, 0);
    check("drain_idle_valid", out_valid, 0);
    if (mode == 0) check("zero_bubble", last_c - first_c, 31);
  endtask

  // ---- bound on total run time ----
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench time limit");
  end

  // ---- main sequence ----
  initial begin
    int rl;
    int snap;

    // 1. reset values, start held during reset is ignored
    #1 reset = 1'b1; start = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_core_reset", core_reset, 1);
    check("rst_core_req", core_req, 0);
    check("rst_mem_sel", mem_sel, 1);
    check("rst_wr_en", mem_wr_en, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_state", state_dbg, 0);
    @(negedge clk); reset = 1'b0; start = 1'b0;
    @(negedge clk); #1;
    check("post_rst_busy", busy, 0);
    check("post_rst_core_reset", core_reset, 0);

    // 1. load 0x00..0x3F, one KICK cycle
    start_job();
    load_bytes(64, 8'h00);
    check("load_wr_count", wr_count, 64);
    check("mem0", mem[0], 8'h00);
    check("mem31", mem[31], 8'h1F);
    check("mem63", mem[63], 8'h3F);
    check_kick();

    // 2. done on RUN cycle 10, zero-bubble drain
    run_core(10, rl);
    check("run_len_10", rl, 10);
    drain(0);
    check("no_wdog_err", timeout_err, 0);

    // 3. toggling out_ready
    start_job();
    load_bytes(64, 8'hFF);
    check("mem5_reload", mem[5], 8'hFA);
    check_kick();
    run_core(3, rl);
    check("run_len_3", rl, 3);
    drain(1);

    // 4. core_done stuck high: ignored in IDLE, KICK, first RUN cycle
    @(negedge clk); core_done = 1'b1;
    @(negedge clk); #1;
    check("done_idle_busy", busy, 0);
    start_job();
    load_bytes(64, 8'h11);
    check_kick();
    #1;
    check("done_run1_req", core_req, 1);
    @(negedge clk); #1;
    check("done_run2_req", core_req, 1);
    @(negedge clk); #1;
    check("done_drain_req", core_req, 0);
    check("done_drain_sel", mem_sel, 1);
    core_done = 1'b0;
    drain(0);

`ifdef CORE_WDOG_EN
    // 5. watchdog: done never comes, abort after 100 RUN cycles, still drain
    start_job();
    load_bytes(64, 8'h22);
    check_kick();
    run_core(0, rl);
    check("wdog_run_len", rl, 100);
    check("wdog_err_set", timeout_err, 1);
    drain(0);
    check("wdog_err_sticky", timeout_err, 1);
    start_job();
    #1;
    check("wdog_err_cleared", timeout_err, 0);
    load_bytes(64, 8'h00);
    check_kick();
    run_core(5, rl);
    check("wdog_done_run_len", rl, 5);
    drain(0);
`endif

    // 6. reset mid-LOAD after 20 beats, then reload from base
    start_job();
    load_bytes(20, 8'h44);
    in_valid = 1'b1; in_data = 8'hEE;
    reset = 1'b1;
    #1;
    check("midload_busy", busy, 0);
    check("midload_in_ready", in_ready, 0);
    check("midload_wr_en", mem_wr_en, 0);
    check("midload_core_reset", core_reset, 1);
    check("midload_mem_sel", mem_sel, 1);
    snap = wr_count;
    @(negedge clk); reset = 1'b0;
    #1;
    check("idle_in_valid_wr_en", mem_wr_en, 0);
    @(negedge clk);
    check("idle_in_valid_no_write", wr_count, snap);
    in_valid = 1'b0;
    start_job();
    load_bytes(64, 8'h55);
    check_kick();
    run_core(5, rl);
    check("reload_run_len", rl, 5);
    drain(0);

    // 7. reset during a stalled DRAIN drops out_valid immediately
    start_job();
    load_bytes(64, 8'h66);
    check_kick();
    run_core(2, rl);
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    check("stalled_valid", out_valid, 1);
    reset = 1'b1;
    #1;
    check("rst_drain_valid", out_valid, 0);
    check("rst_drain_busy", busy, 0);
    @(negedge clk); reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
